// File: rtl/seg7_pkg.sv
// Shared segment encodings and BCD glyph lookup for the seven-segment scan driver.
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Non-decimal nibbles render as 'E' so a datapath fault is visible on the panel.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern_s;
        case (nibble)
            4'd0:    pattern_s = SEG_0;
            4'd1:    pattern_s = SEG_1;
            4'd2:    pattern_s = SEG_2;
            4'd3:    pattern_s = SEG_3;
            4'd4:    pattern_s = SEG_4;
            4'd5:    pattern_s = SEG_5;
            4'd6:    pattern_s = SEG_6;
            4'd7:    pattern_s = SEG_7;
            4'd8:    pattern_s = SEG_8;
            4'd9:    pattern_s = SEG_9;
            default: pattern_s = SEG_E;
        endcase
        return pattern_s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Datapath-side bundle of the scan driver: display controls, BCD snapshot inputs and pin outputs.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    i_en;
    logic                    i_load;
    logic [4*NUM_DIGITS-1:0] i_bcd;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic                    i_blank_lz;
    logic [7:0]              o_seg;
    logic [NUM_DIGITS-1:0]   o_digit;
    logic                    o_frame;

    modport master (
        output i_en, i_load, i_bcd, i_dp, i_blank_lz,
        input  o_seg, o_digit, o_frame
    );

    modport slave (
        input  i_en, i_load, i_bcd, i_dp, i_blank_lz,
        output o_seg, o_digit, o_frame
    );
endinterface

// File: rtl/seg7_decode.sv
// Nibble-to-segment decoder with a blank override, used on the currently scanned digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Leading-zero blanking wins over the glyph.
    always_comb begin
        seg = SEG_OFF;
        if (blank) begin
            seg = SEG_OFF;
        end else begin
            seg = bcd_to_seg(nibble);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with snapshot, leading-zero blanking and frame pulse.
// Optional anti-ghosting dark gap at the start of each digit: define SEG7_GHOST_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 50000,
    parameter bit SEG_ACTIVE_LOW   = 1'b0,
    parameter bit DIGIT_ACTIVE_LOW = 1'b0,
    parameter int BLANK_CYCLES     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    seg7_scan_driver_if.slave bus
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_INV   = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIGIT_INV = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIGIT_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [4*NUM_DIGITS-1:0] bcd_r;
    logic [NUM_DIGITS-1:0]   dp_r;
    logic [PW-1:0]           presc_r;
    logic [IW-1:0]           idx_r;
    logic                    run_r;
    logic [7:0]              seg_r;
    logic [NUM_DIGITS-1:0]   digit_r;
    logic                    frame_r;

    logic [3:0]              nibble_s;
    logic                    dp_bit_s;
    logic [NUM_DIGITS-1:0]   zero_sfx_s;
    logic                    blank_s;
    logic [6:0]              seg7_s;
    logic [7:0]              seg_lit_s;
    logic [NUM_DIGITS-1:0]   digit_lit_s;
    logic                    last_tick_s;
    logic                    wrap_s;
    logic                    gap_s;

`ifdef SEG7_GHOST_BLANK_EN
    assign gap_s = (presc_r < PW'(BLANK_CYCLES));
`else
    logic [31:0] unused_blank_cycles_s;
    assign unused_blank_cycles_s = 32'(BLANK_CYCLES);
    assign gap_s = 1'b0;
`endif

    assign last_tick_s = (presc_r == PRESC_MAX);
    assign wrap_s      = last_tick_s && (idx_r == IDX_MAX);
    assign nibble_s    = bcd_r[{idx_r, 2'b00} +: 4];
    assign dp_bit_s    = dp_r[idx_r];
    assign blank_s     = bus.i_blank_lz && (idx_r != {IW{1'b0}}) && zero_sfx_s[idx_r];
    assign digit_lit_s = DIGIT_ONE << idx_r;

    // zero_sfx_s[k] is set when snapshot nibbles k..top are all zero.
    always_comb begin
        logic all_zero_s;
        all_zero_s = 1'b1;
        zero_sfx_s = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero_s    = all_zero_s && (bcd_r[4*k +: 4] == 4'd0);
            zero_sfx_s[k] = all_zero_s;
        end
    end

    seg7_decode u_decode (
        .nibble (nibble_s),
        .blank  (blank_s),
        .seg    (seg7_s)
    );

    // Logical (1 = lit) pattern for the digit being scanned; DP survives blanking.
    always_comb begin
        seg_lit_s                = 8'h00;
        seg_lit_s[SEG_G:SEG_A]   = seg7_s;
        seg_lit_s[SEG_DP]        = dp_bit_s;
    end

    // Snapshot register: the scan reads only this copy, so a frame never tears.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bcd_r <= {(4*NUM_DIGITS){1'b0}};
            dp_r  <= {NUM_DIGITS{1'b0}};
        end else if (bus.i_load) begin
            bcd_r <= bus.i_bcd;
            dp_r  <= bus.i_dp;
        end else begin
            bcd_r <= bcd_r;
            dp_r  <= dp_r;
        end
    end

    // Prescaler and digit index; run_r delays counting by one edge so digit 0 gets a full period.
    always_ff @(posedge i_clk) begin
        if (i_rst || !bus.i_en) begin
            presc_r <= {PW{1'b0}};
            idx_r   <= {IW{1'b0}};
            run_r   <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (run_r && last_tick_s) begin
                presc_r <= {PW{1'b0}};
                idx_r   <= (idx_r == IDX_MAX) ? {IW{1'b0}} : idx_r + IW'(1);
            end else if (run_r) begin
                presc_r <= presc_r + PW'(1);
                idx_r   <= idx_r;
            end else begin
                presc_r <= presc_r;
                idx_r   <= idx_r;
            end
        end
    end

    // Pin registers; polarity is folded in here only.
    always_ff @(posedge i_clk) begin
        if (i_rst || !bus.i_en || !run_r) begin
            seg_r   <= SEG_INV;
            digit_r <= DIGIT_INV;
            frame_r <= 1'b0;
        end else begin
            seg_r   <= gap_s ? SEG_INV   : (seg_lit_s ^ SEG_INV);
            digit_r <= gap_s ? DIGIT_INV : (digit_lit_s ^ DIGIT_INV);
            frame_r <= wrap_s;
        end
    end

    assign bus.o_seg   = seg_r;
    assign bus.o_digit = digit_r;
    assign bus.o_frame = frame_r;

endmodule
